// File: rtl/time_base.sv
// Time-of-day base: a 1 s prescaler driving a seconds-since-midnight counter,
// with PAUSE/RUN/SET control, field adjust in SET, and synchronous clear.
module time_base #(
  parameter int CLK_DIV = 50000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_stop,
  input  logic        set_en,
  input  logic [1:0]  adj_sel,
  input  logic        adj_inc,
  input  logic        clr,
  output logic [16:0] count,
  output logic        tick,
  output logic        day_wrap,
  output logic [1:0]  state
);

  localparam int              PW        = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0]   PRESC_ONE = PW'(1);
  localparam logic [16:0]     DAY_MAX   = 17'd86399;

  typedef enum logic [1:0] {
    ST_PAUSE = 2'b00,
    ST_RUN   = 2'b01,
    ST_SET   = 2'b10
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_ss_q;
  logic            r_adj_q;
  logic [PW-1:0]   r_presc;
  logic [16:0]     r_count;
  logic            r_tick;
  logic            r_day_wrap;

  logic            w_ss_rise;
  logic            w_adj_rise;
  logic            w_run;
  logic            w_tick;
  logic            w_adj_fire;
  logic [5:0]      w_sec;
  logic [5:0]      w_min;
  logic [4:0]      w_hr;
  logic [16:0]     w_count_adj;

  assign w_ss_rise  = start_stop & ~r_ss_q;
  assign w_adj_rise = adj_inc & ~r_adj_q;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = ST_PAUSE;
    if (set_en) begin
      w_state_next = ST_SET;
    end else begin
      case (r_state)
        ST_PAUSE: w_state_next = w_ss_rise ? ST_RUN : ST_PAUSE;
        ST_RUN:   w_state_next = w_ss_rise ? ST_PAUSE : ST_RUN;
        default:  w_state_next = ST_PAUSE;
      endcase
    end
  end

  // The prescaler only advances while staying in RUN, so leaving RUN drops any partial second.
  assign w_run      = (r_state == ST_RUN) && (w_state_next == ST_RUN);
  assign w_tick     = w_run && (r_presc == PRESC_MAX);
  assign w_adj_fire = (r_state == ST_SET) && w_adj_rise;

  assign w_sec = 6'(r_count % 17'd60);
  assign w_min = 6'((r_count / 17'd60) % 17'd60);
  assign w_hr  = 5'(r_count / 17'd3600);

  // Each field is bumped by adding or subtracting its weight, leaving the other fields untouched.
  always_comb begin
    w_count_adj = r_count;
    case (adj_sel)
      2'b00:   w_count_adj = (w_sec == 6'd59) ? r_count - 17'd59    : r_count + 17'd1;
      2'b01:   w_count_adj = (w_min == 6'd59) ? r_count - 17'd3540  : r_count + 17'd60;
      2'b10:   w_count_adj = (w_hr  == 5'd23) ? r_count - 17'd82800 : r_count + 17'd3600;
      default: w_count_adj = r_count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_PAUSE;
      r_ss_q     <= 1'b0;
      r_adj_q    <= 1'b0;
      r_presc    <= '0;
      r_count    <= '0;
      r_tick     <= 1'b0;
      r_day_wrap <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_ss_q     <= start_stop;
      r_adj_q    <= adj_inc;
      r_tick     <= 1'b0;
      r_day_wrap <= 1'b0;
      if (clr) begin
        r_count <= '0;
        r_presc <= '0;
      end else begin
        r_presc <= (w_run && !w_tick) ? r_presc + PRESC_ONE : '0;
        if (r_count > DAY_MAX) begin
          r_count <= '0;
        end else if (w_tick) begin
          r_tick     <= 1'b1;
          r_day_wrap <= (r_count == DAY_MAX);
          r_count    <= (r_count == DAY_MAX) ? 17'd0 : r_count + 17'd1;
        end else if (w_adj_fire) begin
          r_count <= w_count_adj;
        end
      end
    end
  end

  assign count    = r_count;
  assign tick     = r_tick;
  assign day_wrap = r_day_wrap;
  assign state    = r_state;

endmodule

// File: tb/tb_time_base.sv
// Self-checking bench for time_base: directed scenarios with spec-derived constants,
// then randomized stimulus compared against a seconds/fields reference model.
module tb_time_base;

  localparam int CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_stop = 1'b0;
  logic        set_en = 1'b0;
  logic [1:0]  adj_sel = 2'b00;
  logic        adj_inc = 1'b0;
  logic        clr = 1'b0;
  logic [16:0] count;
  logic        tick;
  logic        day_wrap;
  logic [1:0]  state;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_seen = 0;

  time_base #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .start_stop(start_stop), .set_en(set_en),
    .adj_sel(adj_sel), .adj_inc(adj_inc), .clr(clr),
    .count(count), .tick(tick), .day_wrap(day_wrap), .state(state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (tick) tick_seen++;

  // Reference model: time of day kept as plain seconds, adjusted through h/m/s fields.
  typedef struct {
    int st;     // 0 pause, 1 run, 2 set
    int phase;  // clocks elapsed in the current second
    int cnt;
    bit tick;
    bit wrap;
    bit pss;
    bit padj;
  } model_t;

  model_t m;

  function automatic model_t model_next(model_t c, bit ss, bit se, bit ai, bit cl, int sel);
    model_t n = c;
    bit ss_rise, adj_rise, ticking;
    int h, mi, s;
    ss_rise  = ss && !c.pss;
    adj_rise = ai && !c.padj;
    n.pss  = ss;
    n.padj = ai;
    if (se)              n.st = 2;
    else if (c.st == 2)  n.st = 0;
    else if (ss_rise)    n.st = (c.st == 0) ? 1 : 0;
    else                 n.st = c.st;
    ticking = (c.st == 1) && (n.st == 1) && (c.phase == CLK_DIV - 1);
    n.tick = 0;
    n.wrap = 0;
    if (cl) begin
      n.cnt = 0;
      n.phase = 0;
    end else begin
      n.phase = (c.st == 1 && n.st == 1 && !ticking) ? c.phase + 1 : 0;
      if (ticking) begin
        n.tick = 1;
        n.wrap = (c.cnt == 86399);
        n.cnt  = (c.cnt + 1) % 86400;
      end else if (c.st == 2 && adj_rise) begin
        h  = c.cnt / 3600;
        mi = (c.cnt / 60) % 60;
        s  = c.cnt % 60;
        case (sel)
          0: s  = (s + 1) % 60;
          1: mi = (mi + 1) % 60;
          2: h  = (h + 1) % 24;
          default: ;
        endcase
        n.cnt = h * 3600 + mi * 60 + s;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{default: 0};
    else        m <= model_next(m, start_stop, set_en, adj_inc, clr, int'(adj_sel));
  end

  function automatic logic [20:0] exp_vec();
    return {2'(m.st), m.tick, m.wrap, 17'(m.cnt)};
  endfunction

  task automatic step(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1;
    step();
    start_stop = 1'b0;
  endtask

  task automatic adj_pulses(logic [1:0] sel, int n);
    adj_sel = sel;
    repeat (n) begin
      adj_inc = 1'b1;
      step();
      adj_inc = 1'b0;
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(2);
    n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %b expected 00", state); end
    n_checks++; if (count !== 17'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if ({tick, day_wrap} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b expected 00", {tick, day_wrap}); end
    rst_n = 1'b1;
    step(6);
    n_checks++; if ({state, count} !== 19'd0) begin n_fail++; $display("FAIL reset_idle: state %b count %0d expected 00/0", state, count); end
  endtask

  task automatic test_run_ticks();
    int n_ticks = 0;
    logic exp_t;
    pulse_ss();
    n_checks++; if (state !== 2'b01) begin n_fail++; $display("FAIL run_enter: got %b expected 01", state); end
    for (int k = 1; k <= 12; k++) begin
      step();
      exp_t = (k % 4 == 0);
      if (tick) n_ticks++;
      n_checks++; if ({tick, day_wrap} !== {exp_t, 1'b0}) begin n_fail++; $display("FAIL run_tick_k%0d: got %b expected %b", k, {tick, day_wrap}, {exp_t, 1'b0}); end
    end
    n_checks++; if (count !== 17'd3) begin n_fail++; $display("FAIL run_count: got %0d expected 3", count); end
    n_checks++; if (n_ticks != 3) begin n_fail++; $display("FAIL run_ntick: got %0d expected 3", n_ticks); end
    n_checks++; if (state !== 2'b01) begin n_fail++; $display("FAIL run_state: got %b expected 01", state); end
  endtask

  task automatic test_day_wrap();
    logic exp_t, exp_w;
    set_en = 1'b1; clr = 1'b1;
    step();
    clr = 1'b0;
    n_checks++; if ({state, count} !== {2'b10, 17'd0}) begin n_fail++; $display("FAIL wrap_setclr: state %b count %0d expected 10/0", state, count); end
    adj_pulses(2'b10, 23);
    adj_pulses(2'b01, 59);
    adj_pulses(2'b00, 58);
    n_checks++; if (count !== 17'd86398) begin n_fail++; $display("FAIL wrap_preload: got %0d expected 86398", count); end
    set_en = 1'b0;
    step();
    n_checks++; if ({state, count} !== {2'b00, 17'd86398}) begin n_fail++; $display("FAIL wrap_pause: state %b count %0d expected 00/86398", state, count); end
    pulse_ss();
    for (int k = 1; k <= 8; k++) begin
      step();
      exp_t = (k % 4 == 0);
      exp_w = (k == 8);
      n_checks++; if ({tick, day_wrap} !== {exp_t, exp_w}) begin n_fail++; $display("FAIL wrap_pulse_k%0d: got %b expected %b", k, {tick, day_wrap}, {exp_t, exp_w}); end
      if (k == 4) begin
        n_checks++; if (count !== 17'd86399) begin n_fail++; $display("FAIL wrap_last: got %0d expected 86399", count); end
      end
      if (k == 8) begin
        n_checks++; if (count !== 17'd0) begin n_fail++; $display("FAIL wrap_zero: got %0d expected 0", count); end
      end
    end
  endtask

  task automatic test_adjust();
    int ticks_before;
    set_en = 1'b1; clr = 1'b1;
    step();
    clr = 1'b0;
    ticks_before = tick_seen;
    adj_pulses(2'b01, 59);
    adj_pulses(2'b00, 59);
    n_checks++; if (count !== 17'd3599) begin n_fail++; $display("FAIL adj_preload: got %0d expected 3599", count); end
    adj_pulses(2'b00, 1);
    n_checks++; if (count !== 17'd3540) begin n_fail++; $display("FAIL adj_sec_wrap: got %0d expected 3540", count); end
    adj_sel = 2'b01; adj_inc = 1'b1;
    step();
    n_checks++; if (count !== 17'd0) begin n_fail++; $display("FAIL adj_min_wrap: got %0d expected 0", count); end
    adj_inc = 1'b0;
    step();
    adj_pulses(2'b10, 24);
    n_checks++; if (count !== 17'd0) begin n_fail++; $display("FAIL adj_hr_wrap: got %0d expected 0", count); end
    adj_pulses(2'b10, 1);
    adj_pulses(2'b11, 3);
    n_checks++; if (count !== 17'd3600) begin n_fail++; $display("FAIL adj_none: got %0d expected 3600", count); end
    n_checks++; if (tick_seen != ticks_before) begin n_fail++; $display("FAIL adj_no_tick: got %0d ticks expected 0", tick_seen - ticks_before); end
    n_checks++; if (state !== 2'b10) begin n_fail++; $display("FAIL adj_state: got %b expected 10", state); end
  endtask

  task automatic test_clr();
    set_en = 1'b0;
    step();
    pulse_ss();
    step(3);
    clr = 1'b1;
    step();
    clr = 1'b0;
    n_checks++; if (count !== 17'd0) begin n_fail++; $display("FAIL clr_count: got %0d expected 0", count); end
    n_checks++; if ({tick, day_wrap} !== 2'b00) begin n_fail++; $display("FAIL clr_pulses: got %b expected 00", {tick, day_wrap}); end
    n_checks++; if (state !== 2'b01) begin n_fail++; $display("FAIL clr_state: got %b expected 01", state); end
  endtask

  task automatic test_set_override();
    step(4);
    n_checks++; if ({tick, count} !== {1'b1, 17'd1}) begin n_fail++; $display("FAIL ovr_first_tick: tick %b count %0d expected 1/1", tick, count); end
    step(2);
    set_en = 1'b1; start_stop = 1'b1;
    step();
    start_stop = 1'b0;
    n_checks++; if ({state, tick} !== {2'b10, 1'b0}) begin n_fail++; $display("FAIL ovr_enter: state %b tick %b expected 10/0", state, tick); end
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL ovr_hold_tick%0d: got %b expected 0", k, tick); end
    end
    pulse_ss();
    n_checks++; if (state !== 2'b10) begin n_fail++; $display("FAIL ovr_ss_discard: got %b expected 10", state); end
    set_en = 1'b0;
    step();
    n_checks++; if ({state, count} !== {2'b00, 17'd1}) begin n_fail++; $display("FAIL ovr_exit: state %b count %0d expected 00/1", state, count); end
    pulse_ss();
    for (int k = 1; k <= 4; k++) begin
      step();
      n_checks++; if (tick !== (k == 4)) begin n_fail++; $display("FAIL ovr_phase_k%0d: got %b expected %b", k, tick, (k == 4)); end
    end
    n_checks++; if (count !== 17'd2) begin n_fail++; $display("FAIL ovr_count: got %0d expected 2", count); end
  endtask

  task automatic test_async_reset();
    step(2);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({state, count} !== 19'd0) begin n_fail++; $display("FAIL areset_now: state %b count %0d expected 00/0", state, count); end
    n_checks++; if ({tick, day_wrap} !== 2'b00) begin n_fail++; $display("FAIL areset_pulses: got %b expected 00", {tick, day_wrap}); end
    @(negedge clk);
    rst_n = 1'b1;
    step(6);
    n_checks++; if ({state, count} !== 19'd0) begin n_fail++; $display("FAIL areset_idle: state %b count %0d expected 00/0", state, count); end
    pulse_ss();
    for (int k = 1; k <= 4; k++) begin
      step();
      n_checks++; if (tick !== (k == 4)) begin n_fail++; $display("FAIL areset_phase_k%0d: got %b expected %b", k, tick, (k == 4)); end
    end
  endtask

  task automatic test_random();
    logic [20:0] got, exp;
    for (int i = 0; i < 3000; i++) begin
      got = {state, tick, day_wrap, count};
      exp = exp_vec();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL rand_cyc%0d: got st=%b t=%b w=%b cnt=%0d expected st=%b t=%b w=%b cnt=%0d",
                 i, got[20:19], got[18], got[17], got[16:0], exp[20:19], exp[18], exp[17], exp[16:0]);
      end
      if ($urandom_range(0, 5) == 0)  start_stop = ~start_stop;
      if ($urandom_range(0, 59) == 0) set_en = ~set_en;
      adj_inc = 1'($urandom_range(0, 1));
      adj_sel = 2'($urandom_range(0, 3));
      clr     = ($urandom_range(0, 199) == 0);
      step();
    end
    start_stop = 1'b0; set_en = 1'b0; adj_inc = 1'b0; clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_run_ticks();
    test_day_wrap();
    test_adjust();
    test_clr();
    test_set_override();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/time_base.md
TIME_BASE -- requirements
Module: time_base

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 50000000, giving system clock cycles per 1 s tick (minimum 2).
REQ-002 The block SHALL have port clk, input, 1, system clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset, asynchronous assert and active-low.
REQ-004 The block SHALL have port start_stop, input, 1, synchronous level; each rising edge toggles between PAUSE and RUN.
REQ-005 The block SHALL have port set_en, input, 1, synchronous level; high selects the SET state.
REQ-006 The block SHALL have port adj_sel, input, 2, field to adjust in SET: 00 seconds, 01 minutes, 10 hours, 11 none.
REQ-007 The block SHALL have port adj_inc, input, 1, synchronous level; each rising edge increments the selected field in SET.
REQ-008 The block SHALL have port clr, input, 1, synchronous clear of the time of day.
REQ-009 The block SHALL have port count, output, 17, seconds since midnight, range 0..86399, registered; it feeds the BCD digit splitter directly.
REQ-010 The block SHALL have port tick, output, 1, one-cycle pulse in the cycle count advances by the 1 s tick.
REQ-011 The block SHALL have port day_wrap, output, 1, one-cycle pulse in the cycle count changes from 86399 to 0 by tick.
REQ-012 The block SHALL have port state, output, 2, current FSM state: 00 PAUSE, 01 RUN, 10 SET.

Function
REQ-013 The FSM SHALL have three states, PAUSE, RUN and SET, with 11 unreachable and recovering to PAUSE on the next clock.
REQ-014 Transitions SHALL be evaluated in priority order:
- set_en=1 goes to SET from any state.
- In SET with set_en=0, go to PAUSE.
- A start_stop rising edge in PAUSE goes to RUN.
- A start_stop rising edge in RUN goes to PAUSE.
REQ-015 Rising edges of start_stop and adj_inc SHALL be detected against a one-cycle registered copy of the input; each registered copy resets to 0.
REQ-016 The prescaler SHALL count 0..CLK_DIV-1 only in RUN and SHALL be held at 0 in PAUSE and SET.
REQ-017 In RUN, when the prescaler equals CLK_DIV-1, it SHALL return to 0, count SHALL advance on that same edge, and tick SHALL be 1 for exactly that one cycle.
REQ-018 Count advance SHALL be count+1, except that 86399 SHALL become 0 with day_wrap=1 in the same cycle as tick.
REQ-019 In SET, an adj_inc rising edge SHALL act according to adj_sel, with count updated on the edge after the detected rise (latency 1 cycle):
- adj_sel=00: the seconds field (count mod 60) increments, 59 wraps to 0, and minutes and hours are unchanged.
- adj_sel=01: the minutes field increments, 59 wraps to 0, and seconds and hours are unchanged.
- adj_sel=10: the hours field increments, 23 wraps to 0, and minutes and seconds are unchanged.
- adj_sel=11: nothing changes.
REQ-020 Adjust operations SHALL NOT generate tick or day_wrap.
REQ-021 clr=1 SHALL force count=0 and prescaler=0 on the next edge, overriding a tick or adjust in that cycle, leave the FSM state unaffected, and assert neither tick nor day_wrap.
REQ-022 Start_stop edges arriving while in SET, or while set_en=1, SHALL be discarded.
REQ-023 All arithmetic SHALL keep count within 0..86399 at every clock; any out-of-range value SHALL load 0 on the next edge.

Reset
REQ-024 While rst_n=0, the block SHALL immediately hold count=0, prescaler=0, tick=0, day_wrap=0, state=PAUSE, and both edge-detect registers=0, independent of clk.
REQ-025 After rst_n deasserts, the block SHALL be in PAUSE and need a start_stop rising edge to count; a reset asserted mid-RUN or mid-SET SHALL discard the partial prescaler phase.

Verification (CLK_DIV=4)
REQ-026 Reset, then a start_stop pulse, then 12 clocks: state=01, three tick pulses spaced 4 cycles apart, count=3.
REQ-027 Preload count=86398 via SET (hours 23, minutes 59, seconds 58), then run 8 clocks: count goes 86399 then 0; day_wrap is high only in the cycle count becomes 0, coincident with tick.
REQ-028 In SET with count=3599 (00:59:59): adj_sel=00 with one adj_inc edge gives 3540; adj_sel=01 with one edge gives 0; adj_sel=10 with 24 edges returns to 0; adj_sel=11 gives no change.
REQ-029 In RUN, assert clr in the same cycle as a tick: count=0 the next cycle, tick and day_wrap low, state stays 01.
REQ-030 In RUN with prescaler=2, raise set_en and start_stop together: state=10, prescaler held 0, no tick; drop set_en: state=00, count unchanged.
REQ-031 Assert rst_n low asynchronously between edges during RUN: count=0 and state=00 before the next clk edge.
